// File: rtl/execute_stage.sv
// Execute stage of a five-stage RISC pipeline: operand forwarding, ALU,
// branch/jump resolution and the E->M pipeline register.
module execute_stage #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               JumpE,
    input  logic               BranchE,
    input  logic               ALUSrcE,
    input  logic               JumpSrcE,
    input  logic               ATypeE,
    input  logic [1:0]         ResultSrcE,
    input  logic [2:0]         ALUCtrlE,
    input  logic [D_WIDTH-1:0] RD1E,
    input  logic [D_WIDTH-1:0] RD2E,
    input  logic [D_WIDTH-1:0] ImmExtE,
    input  logic [D_WIDTH-1:0] PCE,
    input  logic [D_WIDTH-1:0] PCplus4E,
    input  logic [A_WIDTH-1:0] RdE,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [D_WIDTH-1:0] ResultW,
    output logic               PCSrcE,
    output logic [D_WIDTH-1:0] PCTargetE,
    output logic               RegWriteM,
    output logic               MemWriteM,
    output logic [1:0]         ResultSrcM,
    output logic [D_WIDTH-1:0] ALUResultM,
    output logic [D_WIDTH-1:0] WriteDataM,
    output logic [D_WIDTH-1:0] PCplus4M,
    output logic [A_WIDTH-1:0] RdM
);

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    // Mask that clears bit 0 of an indirect-jump target.
    localparam logic [D_WIDTH-1:0] LSB_CLEAR = ~{{(D_WIDTH-1){1'b0}}, 1'b1};

    // M-stage pipeline register
    logic               reg_write_m_q,   reg_write_m_d;
    logic               mem_write_m_q,   mem_write_m_d;
    logic [1:0]         result_src_m_q,  result_src_m_d;
    logic [D_WIDTH-1:0] alu_result_m_q,  alu_result_m_d;
    logic [D_WIDTH-1:0] write_data_m_q,  write_data_m_d;
    logic [D_WIDTH-1:0] pc_plus4_m_q,    pc_plus4_m_d;
    logic [A_WIDTH-1:0] rd_m_q,          rd_m_d;

    // Datapath internals
    logic [D_WIDTH-1:0] src_a;
    logic [D_WIDTH-1:0] fwd_b;
    logic [D_WIDTH-1:0] src_b;
    logic [D_WIDTH-1:0] alu_result;
    logic [4:0]         shamt;
    logic               zero;
    logic               branch_taken;
    logic [D_WIDTH-1:0] jalr_sum;

    // Operand A forwarding; the M-stage bypass reads the register's pre-edge value.
    always_comb begin
        src_a = RD1E;
        case (ForwardAE)
            2'b01:   src_a = ResultW;
            2'b10:   src_a = alu_result_m_q;
            default: src_a = RD1E;
        endcase
    end

    // Operand B forwarding, then immediate select; store data stays the forwarded value.
    always_comb begin
        fwd_b = RD2E;
        case (ForwardBE)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = alu_result_m_q;
            default: fwd_b = RD2E;
        endcase
        src_b = ALUSrcE ? ImmExtE : fwd_b;
    end

    // ALU: results truncate to D_WIDTH, shifts use the low five bits of SrcB.
    always_comb begin
        alu_result = '0;
        shamt      = src_b[4:0];
        case (ALUCtrlE)
            ALU_ADD: alu_result = src_a + src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_AND: alu_result = src_a & src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(D_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLL: alu_result = src_a << shamt;
            ALU_SRL: alu_result = src_a >> shamt;
            default: alu_result = '0;
        endcase
    end

    // Branch/jump resolution and redirect target, independent of reset.
    always_comb begin
        zero         = (alu_result == '0);
        branch_taken = BranchE & (zero ^ ATypeE);
        PCSrcE       = JumpE | branch_taken;
        jalr_sum     = src_a + ImmExtE;
        if (JumpSrcE) begin
            PCTargetE = jalr_sum & LSB_CLEAR;
        end else begin
            PCTargetE = PCE + ImmExtE;
        end
    end

    // Next values for the M register: everything in E moves forward each cycle.
    always_comb begin
        reg_write_m_d  = RegWriteE;
        mem_write_m_d  = MemWriteE;
        result_src_m_d = ResultSrcE;
        alu_result_m_d = alu_result;
        write_data_m_d = fwd_b;
        pc_plus4_m_d   = PCplus4E;
        rd_m_d         = RdE;
    end

    // M register: reset wins over capture and discards the instruction in E.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= '0;
        end else begin
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
            rd_m_q         <= rd_m_d;
        end
    end

    assign RegWriteM  = reg_write_m_q;
    assign MemWriteM  = mem_write_m_q;
    assign ResultSrcM = result_src_m_q;
    assign ALUResultM = alu_result_m_q;
    assign WriteDataM = write_data_m_q;
    assign PCplus4M   = pc_plus4_m_q;
    assign RdM        = rd_m_q;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed cases followed by randomized cycles
// checked against a behavioural model of the stage.
module tb_execute_stage;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst;
    logic          RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JumpSrcE, ATypeE;
    logic [1:0]    ResultSrcE;
    logic [2:0]    ALUCtrlE;
    logic [DW-1:0] RD1E, RD2E, ImmExtE, PCE, PCplus4E;
    logic [AW-1:0] RdE;
    logic [1:0]    ForwardAE, ForwardBE;
    logic [DW-1:0] ResultW;
    logic          PCSrcE;
    logic [DW-1:0] PCTargetE;
    logic          RegWriteM, MemWriteM;
    logic [1:0]    ResultSrcM;
    logic [DW-1:0] ALUResultM, WriteDataM, PCplus4M;
    logic [AW-1:0] RdM;

    int n_checks = 0;
    int n_errors = 0;

    // Model of the M register contents
    logic          m_rw, m_mw;
    logic [1:0]    m_rs;
    logic [DW-1:0] m_alu, m_wd, m_pc4;
    logic [AW-1:0] m_rd;

    execute_stage #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .JumpSrcE(JumpSrcE), .ATypeE(ATypeE),
        .ResultSrcE(ResultSrcE), .ALUCtrlE(ALUCtrlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCplus4E(PCplus4E),
        .RdE(RdE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCplus4M(PCplus4M), .RdM(RdM)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] rd);
        if (sel == 2'b01) return ResultW;
        if (sel == 2'b10) return m_alu;
        return rd;
    endfunction

    function automatic logic [DW-1:0] alu_ref(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        int sh;
        sh = int'(b % 32);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 1 : 0;
            3'd6: return a << sh;
            default: return a >> sh;
        endcase
    endfunction

    task automatic set_idle();
        {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JumpSrcE, ATypeE} = '0;
        ResultSrcE = '0; ALUCtrlE = '0;
        RD1E = '0; RD2E = '0; ImmExtE = '0; PCE = '0; PCplus4E = '0;
        RdE = '0; ForwardAE = '0; ForwardBE = '0; ResultW = '0;
    endtask

    task automatic drive_random();
        RegWriteE = 1'($urandom); MemWriteE = 1'($urandom);
        JumpE     = ($urandom_range(0, 3) == 0); BranchE = 1'($urandom);
        ALUSrcE   = 1'($urandom); JumpSrcE = 1'($urandom); ATypeE = 1'($urandom);
        ResultSrcE = 2'($urandom); ALUCtrlE = 3'($urandom);
        RD1E = $urandom; ImmExtE = $urandom; PCE = $urandom; PCplus4E = $urandom;
        // Equal operands now and then so branches are taken
        RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
        RdE = 5'($urandom); ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
        ResultW = $urandom;
        rst = ($urandom_range(0, 19) == 0);
    endtask

    // One cycle: check combinational outputs, clock, update model, check M outputs.
    task automatic step();
        logic [DW-1:0] a, fb, b, res, tgt;
        logic          psrc;
        a    = pick(ForwardAE, RD1E);
        fb   = pick(ForwardBE, RD2E);
        b    = ALUSrcE ? ImmExtE : fb;
        res  = alu_ref(ALUCtrlE, a, b);
        psrc = JumpE || (BranchE && ((res == 0) != ATypeE));
        tgt  = JumpSrcE ? ((a + ImmExtE) & 32'hFFFF_FFFE) : (PCE + ImmExtE);
        #1;
        check("PCSrcE", DW'(PCSrcE), DW'(psrc));
        check("PCTargetE", PCTargetE, tgt);
        @(posedge clk);
        if (rst) begin
            m_rw = 0; m_mw = 0; m_rs = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        end else begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_alu = res;
            m_wd = fb; m_pc4 = PCplus4E; m_rd = RdE;
        end
        #1;
        check("RegWriteM", DW'(RegWriteM), DW'(m_rw));
        check("MemWriteM", DW'(MemWriteM), DW'(m_mw));
        check("ResultSrcM", DW'(ResultSrcM), DW'(m_rs));
        check("ALUResultM", ALUResultM, m_alu);
        check("WriteDataM", WriteDataM, m_wd);
        check("PCplus4M", PCplus4M, m_pc4);
        check("RdM", DW'(RdM), DW'(m_rd));
        @(negedge clk);
    endtask

    initial begin
        m_rw = 0; m_mw = 0; m_rs = 0; m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0;
        set_idle();
        rst = 1'b1;
        @(negedge clk);
        // Reset state
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 2'b11; RD1E = 32'h55; PCplus4E = 32'h44; RdE = 7;
        step();
        check("reset_alu", ALUResultM, 32'h0);
        check("reset_rw", DW'(RegWriteM), 32'h0);
        rst = 1'b0;

        // add with register operands
        set_idle();
        RD1E = 5; RD2E = 7; RegWriteE = 1; RdE = 3;
        step();
        check("add_alu", ALUResultM, 32'd12);
        check("add_wd", WriteDataM, 32'd7);
        check("add_rd", DW'(RdM), 32'd3);
        check("add_rw", DW'(RegWriteM), 32'd1);

        // Forwarding: first put 0x10 into ALUResultM, then sub with both bypasses
        set_idle();
        RD1E = 32'h10;
        step();
        set_idle();
        ResultW = 32'h20; ForwardAE = 2'b10; ForwardBE = 2'b01; ALUCtrlE = 3'b001;
        RD1E = 32'h999; RD2E = 32'h777;
        step();
        check("fwd_alu", ALUResultM, 32'hFFFF_FFF0);
        check("fwd_wd", WriteDataM, 32'h20);

        // Store data stays FwdB even with immediate operand
        set_idle();
        RD1E = 1; RD2E = 32'hABCD; ImmExtE = 32'h100; ALUSrcE = 1; MemWriteE = 1;
        step();
        check("imm_alu", ALUResultM, 32'h101);
        check("imm_wd", WriteDataM, 32'hABCD);

        // beq taken, then bne not taken
        set_idle();
        BranchE = 1; RD1E = 9; RD2E = 9; PCE = 32'h100; ImmExtE = 32'h20; ALUCtrlE = 3'b001;
        #1;
        check("beq_src", DW'(PCSrcE), 32'd1);
        check("beq_tgt", PCTargetE, 32'h120);
        step();
        ATypeE = 1;
        #1;
        check("bne_src", DW'(PCSrcE), 32'd0);
        step();

        // jalr
        set_idle();
        JumpE = 1; JumpSrcE = 1; RD1E = 32'h203; ImmExtE = 4; PCplus4E = 32'h48; RegWriteE = 1;
        #1;
        check("jalr_tgt", PCTargetE, 32'h206);
        check("jalr_src", DW'(PCSrcE), 32'd1);
        step();
        check("jalr_pc4", PCplus4M, 32'h48);

        // slt / srl / sll corner cases
        set_idle();
        ALUCtrlE = 3'b101; RD1E = 32'hFFFF_FFFF; RD2E = 1;
        step();
        check("slt", ALUResultM, 32'd1);
        ALUCtrlE = 3'b111; RD1E = 32'h8000_0000; RD2E = 31;
        step();
        check("srl", ALUResultM, 32'd1);
        ALUCtrlE = 3'b110; RD1E = 32'h3; RD2E = 32'h21;
        step();
        check("sll", ALUResultM, 32'h6);

        // Flushed E: zero controls -> no writes, no redirect
        set_idle();
        RD1E = 4; RD2E = 4; ALUCtrlE = 3'b001;
        #1;
        check("flush_src", DW'(PCSrcE), 32'd0);
        step();
        check("flush_mw", DW'(MemWriteM), 32'd0);

        // Reset mid-stream, then normal capture
        set_idle();
        RegWriteE = 1; MemWriteE = 1; RD1E = 32'h30; RD2E = 32'h12; RdE = 9; PCplus4E = 32'h80;
        rst = 1;
        step();
        check("mid_rst_alu", ALUResultM, 32'h0);
        check("mid_rst_rd", DW'(RdM), 32'h0);
        rst = 0;
        step();
        check("post_rst_alu", ALUResultM, 32'h42);
        check("post_rst_pc4", PCplus4M, 32'h80);

        // Randomized cycles against the model
        for (int i = 0; i < 400; i++) begin
            drive_random();
            step();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
- REQ-001 SHALL have parameter D_WIDTH, default 32, datapath width.
- REQ-002 SHALL have parameter A_WIDTH, default 5, register-address width.
- REQ-003 SHALL have ports:
  - clk  in  1  single clock; all state updates on rising edge.
  - rst  in  1  synchronous, active-high reset.
  - RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, JumpSrcE, ATypeE  in  1 each  E-stage controls.
  - ResultSrcE  in  2  result-select control, carried to M.
  - ALUCtrlE  in  3  ALU operation.
  - RD1E, RD2E, ImmExtE, PCE, PCplus4E  in  D_WIDTH  E-stage operands.
  - RdE  in  A_WIDTH  destination register.
  - ForwardAE, ForwardBE  in  2  forwarding selects from the hazard unit.
  - ResultW  in  D_WIDTH  writeback-stage result.
  - PCSrcE  out  1  redirect fetch, combinational.
  - PCTargetE  out  D_WIDTH  redirect address, combinational.
  - RegWriteM, MemWriteM  out  1  registered controls.
  - ResultSrcM  out  2  registered control.
  - ALUResultM, WriteDataM, PCplus4M  out  D_WIDTH  registered data.
  - RdM  out  A_WIDTH  registered destination.

Function
- REQ-004 SrcA SHALL be: ForwardAE 00 -> RD1E; 01 -> ResultW; 10 -> ALUResultM; 11 -> RD1E.
- REQ-005 Forwarded B (FwdB) SHALL use the same mapping on ForwardBE with RD2E; SrcB SHALL be ImmExtE when ALUSrcE=1, otherwise FwdB.
- REQ-006 ALU SHALL decode ALUCtrlE as follows, with results truncated to D_WIDTH and no overflow flag:
  - 000 add; 001 sub; 010 and; 011 or; 100 xor.
  - 101 slt (signed, result 1/0).
  - 110 sll by SrcB[4:0]; 111 srl by SrcB[4:0].
- REQ-007 Zero SHALL be 1 when the ALU result equals 0.
- REQ-008 The taken condition SHALL be (BranchE and (Zero xor ATypeE)); ATypeE=1 selects branch-on-not-equal.
- REQ-009 PCSrcE SHALL equal JumpE or the taken condition, combinationally in the same cycle.
- REQ-010 PCTargetE SHALL be:
  - JumpSrcE=0: PCE + ImmExtE.
  - JumpSrcE=1: (SrcA + ImmExtE) with bit 0 forced to 0.
  - Wraps modulo 2^D_WIDTH.
- REQ-011 On each rising edge with rst=0, the M registers SHALL capture RegWriteE, MemWriteE, ResultSrcE, ALU result, FwdB (as WriteDataM), RdE and PCplus4E; latency is one cycle.
- REQ-012 WriteDataM SHALL always carry FwdB, never ImmExtE, regardless of ALUSrcE.
- REQ-013 The block SHALL have no stall input; the M register advances every cycle.
- REQ-014 A flush of E SHALL arrive as zeroed E controls; the block SHALL then produce no writes in M and PCSrcE=0.
- REQ-015 Forwarding from ALUResultM SHALL use the register's current (pre-edge) value in the same cycle, forming a one-instruction-back bypass.
- REQ-016 When JumpE=1 and BranchE=1 both occur, PCSrcE SHALL be 1 and the target SHALL follow JumpSrcE.
- REQ-017 RdE=0 SHALL be carried unchanged; suppressing writes to x0 is the register file's job.

Reset
- REQ-018 With rst=1 at a rising edge, the following SHALL clear to 0: RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, RdM, PCplus4M.
- REQ-019 Reset SHALL take priority over capture; when asserted mid-stream, the instruction in E is discarded and M shows zeros on the next cycle.
- REQ-020 PCSrcE and PCTargetE SHALL stay combinational and unaffected by rst.

Verification
- REQ-021 add, reg operands:
  - Stimulus: RD1E=5, RD2E=7, ALUCtrlE=000, ALUSrcE=0, forwards 00, RegWriteE=1, RdE=3.
  - Response: next cycle ALUResultM=12, WriteDataM=7, RdM=3, RegWriteM=1.
- REQ-022 Forwarding:
  - Stimulus: ALUResultM=0x10, ResultW=0x20, ForwardAE=10, ForwardBE=01, ALUCtrlE=001.
  - Response: ALU result 0xFFFFFFF0 captured; WriteDataM=0x20.
- REQ-023 Branches:
  - beq taken: BranchE=1, ATypeE=0, RD1E=RD2E=9, PCE=0x100, ImmExtE=0x20 -> PCSrcE=1, PCTargetE=0x120.
  - bne: same stimulus with ATypeE=1 -> PCSrcE=0.
- REQ-024 jalr:
  - Stimulus: JumpE=1, JumpSrcE=1, RD1E=0x203, ImmExtE=4, PCplus4E=0x48.
  - Response: PCTargetE=0x206, PCSrcE=1; next cycle PCplus4M=0x48.
- REQ-025 slt/shift:
  - slt with SrcA=0xFFFFFFFF, SrcB=1 -> 1.
  - srl of 0x80000000 by 31 -> 1.
  - sll by SrcB=0x21 shifts by 1.
- REQ-026 Reset mid-stream: with valid controls in E, assert rst for one edge -> all M outputs 0; release -> next edge captures normally.
